pio_edge_event_master: RTL and testbench
========================================

Name: pio_edge_event_master

Overview:
- Avalon-MM initiator that services a 2-bit edge-capture PIO slave: programs its irq_mask, reacts to its irq, reads and clears the edge-capture register, and presents the captured bits as a valid/ready event stream.
- Sits between the EOP PIO slave and the vision-pipeline control logic, so frame-end events need no Nios software intervention.

Parameters:
- WIDTH, 2, PIO input width; event width.
- IRQ_MASK, 2'b11, value written to the mask register after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when low, the FSM stays in S_IDLE and issues no new transactions
- irq  in  1  PIO interrupt
- av_address  out  2  slave register address
- av_chipselect  out  1  slave select
- av_write_n  out  1  active-low write strobe
- av_writedata  out  32  write data
- av_readdata  in  32  slave read data, registered in the slave, valid one cycle after the address is presented
- event_valid  out  1  event available
- event_data  out  WIDTH  edge bits captured since the last accepted event
- event_ready  in  1  consumer accepts the event
- overrun  out  1  one-cycle pulse: a new capture was merged into an unaccepted event

Behaviour:
- Reset values (asynchronous): state = S_INIT; av_chipselect = 0; av_write_n = 1; av_address = 0; av_writedata = 0; event_valid = 0; event_data = 0; overrun = 0.
- Idle bus (every state without a transaction): chipselect = 0, write_n = 1, address = 0, writedata = 0.
- Slave has no waitrequest; every transaction completes in one cycle.
- Bus outputs and event outputs are registered.
- FSM:
  - S_INIT: one-cycle write, address 2, writedata = zero-extended IRQ_MASK. Next state S_IDLE.
  - S_IDLE: if irq && enable, go to S_READ; otherwise stay.
  - S_READ: chipselect = 1, write_n = 1, address = 3. Next state S_CLEAR.
  - S_CLEAR: chipselect = 1, write_n = 0, address = 3, writedata = 0. In the same cycle, sample av_readdata[WIDTH-1:0] into cap. Next state S_IDLE.
- Latency and timing:
  - irq high at cycle t gives S_READ at t+1 and S_CLEAR at t+2.
  - The slave clears the register at the end of t+2.
  - irq is low by t+3.
  - event_valid rises at t+3 when cap != 0.
  - While irq stays low, S_IDLE does not re-trigger: the earliest next S_READ is t+4.
- cap == 0 (spurious interrupt): no event, no overrun.
- Event register, evaluated on the S_CLEAR sampling edge:
  - !event_valid or (event_valid && event_ready): load event_data = cap, event_valid = (cap != 0).
  - event_valid && !event_ready && cap != 0: event_data |= cap, overrun pulses for 1 cycle.
- Acceptance: event_valid && event_ready with no concurrent load clears event_valid on the next edge. event_data holds its value.
- Stability: event_data is stable while event_valid && !event_ready.
- Known loss window: an edge that reaches the slave's capture register in the S_CLEAR cycle is erased by the clear, because clear has priority in the slave. This is an accepted limitation, documented for software.
- enable low during S_READ or S_CLEAR: the sequence completes, then the FSM holds in S_IDLE.
- Reset mid-transaction: all outputs return to reset values immediately. S_INIT re-programs the mask when reset is released.

Decomposition:
- Shared package pio_master_pkg:
  - state enum {S_INIT, S_IDLE, S_READ, S_CLEAR}
  - constants PIO_ADDR_DATA = 2'd0, PIO_ADDR_IRQMASK = 2'd2, PIO_ADDR_EDGECAP = 2'd3
- Optional sub-module pio_event_buffer: the one-entry merge/overrun holding register with the valid/ready handshake, verifiable on its own.
- Everything else stays in the top-level FSM.

Test Plan:
- Reset release: exactly one write cycle, address 2, writedata 0x00000003; then the bus stays idle while irq = 0.
- Slave model edge_capture = 2'b01, irq raised at t, event_ready = 1: read address 3 at t+1; clear write at t+2; event_valid at t+3 with event_data = 2'b01, accepted the same cycle; event_valid low at t+4.
- event_ready = 0 holding event 2'b01, second irq with capture 2'b10: event_data becomes 2'b11; overrun pulses for one cycle; event_valid stays high; the consumer later receives 2'b11 once.
- Spurious irq with capture 2'b00: read and clear still occur; event_valid stays 0; no overrun.
- enable = 0 with irq held high for 20 cycles: no chipselect. Raising enable starts S_READ on the next cycle.
- Reset asserted during S_CLEAR: chipselect drops the same cycle. After release the mask write repeats and the pending event is discarded (event_valid = 0).

Source files
------------

// File: rtl/pio_master_pkg.sv
// ============================================================================
// Module   : pio_master_pkg
// Purpose  : FSM states and edge-capture PIO register map.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pio_master_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pio_event_buffer.sv
// ============================================================================
// Module   : pio_event_buffer
// Purpose  : One-entry event holder; merges captures into an unaccepted event.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pio_event_buffer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] cap,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_data,
  input  logic             event_ready,
  output logic             overrun
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || event_ready) begin
        data_d  = cap;
        valid_d = (cap != '0);
      end else if (cap != '0) begin
        // Consumer still owns the old event: fold new edges in and flag it.
        data_d    = data_q | cap;
        overrun_d = 1'b1;
      end
    end else if (valid_q && event_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign event_valid = valid_q;
  assign event_data  = data_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: rtl/pio_edge_event_master.sv
// ============================================================================
// Module   : pio_edge_event_master
// Purpose  : Avalon-MM initiator servicing an edge-capture PIO as an event stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pio_edge_event_master
  import pio_master_pkg::*;
#(
  parameter int               WIDTH    = 2,
  parameter logic [WIDTH-1:0] IRQ_MASK = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq,
  output logic [1:0]       av_address,
  output logic             av_chipselect,
  output logic             av_write_n,
  output logic [31:0]      av_writedata,
  input  logic [31:0]      av_readdata,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_data,
  input  logic             event_ready,
  output logic             overrun
);

  state_t      state_q, state_d;
  logic        cs_q, cs_d;
  logic        write_n_q, write_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic             w_load;
  logic [WIDTH-1:0] w_cap;
  logic             unused_readdata;

  // Bus outputs are registered from the state being entered, so each
  // transaction is on the bus during the cycle its state is current.
  // The mask write leaves S_INIT and is therefore seen one cycle after reset.
  always_comb begin
    state_d   = state_q;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    addr_d    = PIO_ADDR_DATA;
    wdata_d   = '0;
    unique case (state_q)
      S_INIT: begin
        state_d   = S_IDLE;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = PIO_ADDR_IRQMASK;
        wdata_d   = {{(32-WIDTH){1'b0}}, IRQ_MASK};
      end
      S_IDLE: begin
        if (irq && enable) begin
          state_d = S_READ;
          cs_d    = 1'b1;
          addr_d  = PIO_ADDR_EDGECAP;
        end
      end
      S_READ: begin
        state_d   = S_CLEAR;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = PIO_ADDR_EDGECAP;
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      addr_q    <= PIO_ADDR_DATA;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign av_chipselect = cs_q;
  assign av_write_n    = write_n_q;
  assign av_address    = addr_q;
  assign av_writedata  = wdata_q;

  // Registered read data from S_READ is on the bus during S_CLEAR.
  assign w_load          = (state_q == S_CLEAR);
  assign w_cap           = av_readdata[WIDTH-1:0];
  assign unused_readdata = ^av_readdata[31:WIDTH];

  pio_event_buffer #(
    .WIDTH (WIDTH)
  ) u_event_buffer (
    .clk         (clk),
    .reset       (reset),
    .load        (w_load),
    .cap         (w_cap),
    .event_valid (event_valid),
    .event_data  (event_data),
    .event_ready (event_ready),
    .overrun     (overrun)
  );

endmodule

`default_nettype wire

// File: tb/tb_pio_edge_event_master.sv
// ============================================================================
// Module   : tb_pio_edge_event_master
// Purpose  : Directed self-checking bench with a behavioural edge-capture PIO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pio_edge_event_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        ready = 1'b1;
  wire logic   irq;
  logic [1:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        event_valid;
  logic [1:0]  event_data;
  logic        overrun;

  logic [1:0]  edge_cap;
  logic [1:0]  mask_reg;
  logic [1:0]  inj = 2'b00;
  logic        force_irq = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int a0;
  int cnt;

  always #5 clk = ~clk;

  pio_edge_event_master #(
    .WIDTH    (2),
    .IRQ_MASK (2'b11)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .irq           (irq),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata),
    .av_readdata   (av_readdata),
    .event_valid   (event_valid),
    .event_data    (event_data),
    .event_ready   (ready),
    .overrun       (overrun)
  );

  // Edge-capture PIO slave: registered read data, clear wins over new edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap    <= 2'b00;
      mask_reg    <= 2'b00;
      av_readdata <= 32'd0;
    end else begin
      av_readdata <= 32'd0;
      if (av_chipselect && av_write_n) begin
        case (av_address)
          2'd2:    av_readdata <= {30'd0, mask_reg};
          2'd3:    av_readdata <= {30'd0, edge_cap};
          default: av_readdata <= 32'd0;
        endcase
      end
      if (av_chipselect && !av_write_n && av_address == 2'd2)
        mask_reg <= av_writedata[1:0];
      if (av_chipselect && !av_write_n && av_address == 2'd3)
        edge_cap <= 2'b00;
      else
        edge_cap <= edge_cap | inj;
    end
  end

  assign irq = (|(edge_cap & mask_reg)) | force_irq;

  always @(posedge clk) begin
    if (!reset && event_valid && ready) n_accept++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle with irq high.
  task automatic inject(input logic [1:0] b);
    @(negedge clk);
    inj = b;
    @(negedge clk);
    inj = 2'b00;
  endtask

  task automatic check_idle_bus(input string tag);
    check_eq({tag, "_cs"},   {31'd0, av_chipselect}, 32'd0);
    check_eq({tag, "_wn"},   {31'd0, av_write_n},    32'd1);
    check_eq({tag, "_addr"}, {30'd0, av_address},    32'd0);
    check_eq({tag, "_wd"},   av_writedata,           32'd0);
  endtask

  task automatic check_bus(input string tag, input logic wn, input logic [1:0] addr,
                           input logic [31:0] wd);
    check_eq({tag, "_cs"},   {31'd0, av_chipselect}, 32'd1);
    check_eq({tag, "_wn"},   {31'd0, av_write_n},    {31'd0, wn});
    check_eq({tag, "_addr"}, {30'd0, av_address},    {30'd0, addr});
    if (!wn) check_eq({tag, "_wd"}, av_writedata, wd);
  endtask

  initial begin
    // Reset values and the single mask write after release
    step(2);
    check_idle_bus("rst");
    check_eq("rst_valid", {31'd0, event_valid}, 32'd0);
    check_eq("rst_data",  {30'd0, event_data},  32'd0);
    check_eq("rst_ovr",   {31'd0, overrun},     32'd0);
    reset = 1'b0;
    step(1);
    check_bus("init_wr", 1'b0, 2'd2, 32'h0000_0003);
    step(1);
    check_idle_bus("init_after");
    check_eq("init_mask", {30'd0, mask_reg}, 32'd3);
    cnt = 0;
    repeat (5) begin
      step(1);
      if (av_chipselect) cnt++;
    end
    check_eq("init_quiet_cs", cnt, 0);

    // Single event, accepted immediately
    ready = 1'b1;
    a0 = n_accept;
    inject(2'b01);
    check_eq("ev1_t_cs", {31'd0, av_chipselect}, 32'd0);
    step(1);
    check_bus("ev1_rd", 1'b1, 2'd3, 32'd0);
    step(1);
    check_bus("ev1_clr", 1'b0, 2'd3, 32'd0);
    check_eq("ev1_clr_valid", {31'd0, event_valid}, 32'd0);
    step(1);
    check_eq("ev1_valid", {31'd0, event_valid}, 32'd1);
    check_eq("ev1_data",  {30'd0, event_data},  32'd1);
    check_eq("ev1_idle",  {31'd0, av_chipselect}, 32'd0);
    step(1);
    check_eq("ev1_drop",  {31'd0, event_valid}, 32'd0);
    check_eq("ev1_hold",  {30'd0, event_data},  32'd1);
    check_eq("ev1_acc",   n_accept - a0, 1);

    // Merge into a held event with overrun
    ready = 1'b0;
    inject(2'b01);
    step(3);
    check_eq("mrg_valid1", {31'd0, event_valid}, 32'd1);
    check_eq("mrg_data1",  {30'd0, event_data},  32'd1);
    step(2);
    check_eq("mrg_stable", {30'd0, event_data},  32'd1);
    inject(2'b10);
    step(3);
    check_eq("mrg_data2",  {30'd0, event_data},  32'd3);
    check_eq("mrg_ovr",    {31'd0, overrun},     32'd1);
    check_eq("mrg_valid2", {31'd0, event_valid}, 32'd1);
    step(1);
    check_eq("mrg_ovr_end", {31'd0, overrun},    32'd0);
    check_eq("mrg_data3",  {30'd0, event_data},  32'd3);
    a0 = n_accept;
    ready = 1'b1;
    step(1);
    check_eq("mrg_drop",   {31'd0, event_valid}, 32'd0);
    step(2);
    check_eq("mrg_acc",    n_accept - a0, 1);

    // Spurious interrupt: bus activity but no event
    @(negedge clk);
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    check_bus("sp_rd", 1'b1, 2'd3, 32'd0);
    step(1);
    check_bus("sp_clr", 1'b0, 2'd3, 32'd0);
    step(1);
    check_eq("sp_valid", {31'd0, event_valid}, 32'd0);
    check_eq("sp_ovr",   {31'd0, overrun},     32'd0);
    step(1);
    check_eq("sp_valid2", {31'd0, event_valid}, 32'd0);

    // enable low blocks servicing of a held irq
    ready  = 1'b0;
    enable = 1'b0;
    inject(2'b01);
    cnt = 0;
    repeat (20) begin
      step(1);
      if (av_chipselect) cnt++;
    end
    check_eq("dis_cs_cnt", cnt, 0);
    enable = 1'b1;
    step(1);
    check_bus("en_rd", 1'b1, 2'd3, 32'd0);
    step(1);
    check_bus("en_clr", 1'b0, 2'd3, 32'd0);
    step(1);
    check_eq("en_valid", {31'd0, event_valid}, 32'd1);
    check_eq("en_data",  {30'd0, event_data},  32'd1);

    // Reset during S_CLEAR discards the pending event and re-programs the mask
    inject(2'b10);
    step(1);
    check_bus("rc_rd", 1'b1, 2'd3, 32'd0);
    step(1);
    check_bus("rc_clr", 1'b0, 2'd3, 32'd0);
    reset = 1'b1;
    #1;
    check_idle_bus("rc_async");
    check_eq("rc_valid", {31'd0, event_valid}, 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    check_bus("rc_init_wr", 1'b0, 2'd2, 32'h0000_0003);
    check_eq("rc_valid2", {31'd0, event_valid}, 32'd0);
    step(1);
    check_idle_bus("rc_after");
    step(3);
    check_eq("rc_valid3", {31'd0, event_valid}, 32'd0);
    check_eq("rc_cs",     {31'd0, av_chipselect}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
